// File: rtl/booth_radix4_mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// BOOTH_UNSIGNED_EN adds one extra iteration to cover the 2-bit operand extension.
package booth_radix4_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Magnitude of a recoded Booth digit; the sign travels separately.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    PM1  = 2'd1,
    PM2  = 2'd2
  } digit_mag_e;

  function automatic int calc_iters(input int width);
`ifdef BOOTH_UNSIGNED_EN
    return width / 2 + 1;
`else
    return width / 2;
`endif
  endfunction

endpackage

// File: rtl/booth_radix4_mult_recode.sv
// Radix-4 Booth recoder: maps triplet {q[1],q[0],q_neg} to digit magnitude and sign.
module booth_recode
  import booth_radix4_mult_pkg::*;
(
  input  logic [2:0]  triplet,
  output digit_mag_e  mag,
  output logic        neg
);

  always_comb begin
    mag = ZERO;
    neg = 1'b0;
    unique case (triplet)
      3'b000, 3'b111: begin mag = ZERO; neg = 1'b0; end
      3'b001, 3'b010: begin mag = PM1;  neg = 1'b0; end
      3'b011:         begin mag = PM2;  neg = 1'b0; end
      3'b100:         begin mag = PM2;  neg = 1'b1; end
      3'b101, 3'b110: begin mag = PM1;  neg = 1'b1; end
      default:        begin mag = ZERO; neg = 1'b0; end
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock.
// Define BOOTH_UNSIGNED_EN to add the signed_mode port and unsigned operand support.
module booth_radix4_mult
  import booth_radix4_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start,
  output logic                 ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = calc_iters(WIDTH);
  localparam int EW = 2 * N;          // extended multiplier width
  localparam int AW = EW + 2;         // accumulator holds +-2M without overflow
  localparam int CW = $clog2(N + 1);

  state_e          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand;
  logic [EW-1:0]   q;
  logic            q_neg;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   a_ext;
  logic [EW-1:0]   b_ext;
  digit_mag_e      dig_mag;
  logic            dig_neg;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_nxt;
  logic [EW-1:0]   q_nxt;
  logic [2*WIDTH-1:0] result;

  always_comb begin
`ifdef BOOTH_UNSIGNED_EN
    a_ext = {{(AW-WIDTH){signed_mode & a[WIDTH-1]}}, a};
    b_ext = {{(EW-WIDTH){signed_mode & b[WIDTH-1]}}, b};
`else
    a_ext = {{(AW-WIDTH){a[WIDTH-1]}}, a};
    b_ext = b;
`endif
  end

  booth_recode u_recode (
    .triplet ({q[1], q[0], q_neg}),
    .mag     (dig_mag),
    .neg     (dig_neg)
  );

  // Subtraction is add of the inverted operand with carry-in.
  always_comb begin
    addend = '0;
    case (dig_mag)
      PM1:     addend = mcand;
      PM2:     addend = {mcand[AW-2:0], 1'b0};
      default: addend = '0;
    endcase
    sum     = acc + (dig_neg ? ~addend : addend) + AW'(dig_neg);
    acc_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt   = {sum[1:0], q[EW-1:2]};
    result  = (2*WIDTH)'({acc, q});
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      q       <= '0;
      q_neg   <= 1'b0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            ready <= 1'b0;
            acc   <= '0;
            mcand <= a_ext;
            q     <= b_ext;
            q_neg <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Final RUN cycle only publishes the result, keeping latency at N+1.
          if (cnt == CW'(N)) begin
            state   <= DONE;
            busy    <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b1;
            product <= result;
          end else begin
            acc   <= acc_nxt;
            q     <= q_nxt;
            q_neg <= q[1];
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed self-checking bench for booth_radix4_mult at WIDTH=32.
module tb_booth_radix4_mult;

  localparam int W = 32;
`ifdef BOOTH_UNSIGNED_EN
  localparam int N = W / 2 + 1;
`else
  localparam int N = W / 2;
`endif

  logic            clk;
  logic            rst_b;
  logic            start;
  logic            ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            signed_mode;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int checks = 0;
  int errors = 0;

  booth_radix4_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .ready       (ready),
    .a           (a),
    .b           (b),
`ifdef BOOTH_UNSIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one multiply, then checks latency, product and the single-cycle done pulse.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic sm, input logic [2*W-1:0] exp, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= N + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk(64'(lat), 64'(N + 1), {tag, "_latency"});
    chk(product, exp, {tag, "_product"});
    @(posedge clk); #1;
    chk(64'(done), 64'd0, {tag, "_done_single"});
    chk(64'(ready), 64'd1, {tag, "_ready_after"});
  endtask

  initial begin
    int ndone;
    int lat;
    rst_b = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b1;
    #3 rst_b = 1'b0;
    #10;
    chk(product, 64'd0, "reset_product");
    chk(64'(ready), 64'd1, "reset_ready");
    chk(64'(busy), 64'd0, "reset_busy");
    chk(64'(done), 64'd0, "reset_done");
    @(negedge clk); rst_b = 1'b1;

    run_op(32'd2, 32'd3, 1'b1, 64'd6, "two_times_three");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, "neg1_sq");
    run_op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "min_sq");
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000, "min_max");
    run_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001, "max_sq");
    run_op(32'h00000000, 32'h12345678, 1'b1, 64'd0, "zero_operand");
`ifdef BOOTH_UNSIGNED_EN
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "unsigned_max_sq");
    run_op(32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000, "unsigned_2pow");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, "signed_mode_neg1_sq");
`endif

    // start pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    a = 32'd100; b = 32'hFFFFFFF9; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(64'(busy), 64'd1, "midrun_busy");
    start = 1'b1; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = 0;
    for (int k = 5; k <= 2 * N + 6; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        lat = k;
      end
    end
    chk(64'(ndone), 64'd1, "midrun_done_count");
    chk(64'(lat), 64'(N + 1), "midrun_latency");
    chk(product, 64'hFFFFFFFFFFFFFD44, "midrun_product");

    // asynchronous reset during iteration 5
    @(negedge clk);
    a = 32'h00012345; b = 32'h00000777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk(product, 64'd0, "abort_product");
    chk(64'(ready), 64'd1, "abort_ready");
    chk(64'(busy), 64'd0, "abort_busy");
    chk(64'(done), 64'd0, "abort_done");
    @(negedge clk); rst_b = 1'b1;
    run_op(32'd7, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB, "after_reset");

    // back-to-back: start held high across DONE
    @(negedge clk);
    a = 32'd5; b = 32'd6; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    a = 32'hFFFFFFFC; b = 32'd9;
    lat = 0;
    for (int k = 1; k <= N + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk(64'(lat), 64'(N + 1), "b2b_first_latency");
    chk(product, 64'd30, "b2b_first_product");
    @(posedge clk); #1;
    start = 1'b0;
    chk(64'(busy), 64'd1, "b2b_second_accepted");
    lat = 0;
    for (int k = 1; k <= N + 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    // Second pulse lands N+2 edges after the first: N+1 idle-done cycles between them.
    chk(64'(lat), 64'(N + 1), "b2b_second_latency");
    chk(product, 64'hFFFFFFFFFFFFFFDC, "b2b_second_product");
    @(posedge clk); #1;
    chk(64'(done), 64'd0, "b2b_done_single");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
